ex_div_ctrl: RTL and testbench
==============================

# ex_div_ctrl

Multi-cycle 32-bit integer divide sequencer for the execute stage. It serves DIV.W, DIV.WU, MOD.W and MOD.WU. It accepts operands and a start pulse from the execute stage and runs a one-bit-per-cycle restoring division under a four-state FSM. It returns quotient and remainder together with a ready flag, which the execute stage uses to drop its pipeline stall request.

## Interface
Parameters:
- `DIV_W`, 32: operand width. The iteration count equals `DIV_W`.

Ports:
- `clk`  in  1  clock. All state updates happen on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-low; `RstEnable` is 1'b0.
- `signed_div_i`  in  1  1 selects signed (two's complement), 0 selects unsigned.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  `DivStart`/`DivStop`. Held high by the execute stage until it samples `ready_o`.
- `cancel_i`  in  1  abort request, driven on pipeline flush.
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}.
- `ready_o`  out  1  `DivResultReady`/`DivResultNotReady`.

## Operation
- FSM states: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`.
- Reset values: state=`DivFree`, `result_o`=0, `ready_o`=`DivResultNotReady`, counter=0.
- **`DivFree`**
  - If `start_i` is high and `cancel_i` is low:
    - Divisor == 0: go to `DivByZero`.
    - Otherwise: latch the operand magnitudes (two's-complement negate when `signed_div_i` is set and bit 31 is set), latch both sign bits, clear the counter and the 65-bit working register (dividend magnitude in bits [31:0]), then go to `DivOn`.
  - Otherwise: hold `ready_o` low and `result_o` at 0.
- **`DivByZero`**
  - Go to `DivEnd` with quotient=0xFFFFFFFF and remainder=the raw dividend, regardless of signedness.
- **`DivOn`**, while counter < 32, one step per cycle:
  - Shift the working register left by 1.
  - Trial-subtract the divisor magnitude from bits [64:32].
  - If the result is non-negative, write it back and set quotient bit 0 to 1; otherwise set it to 0.
  - Increment the counter.
- **`DivOn`**, when counter == 32:
  - Sign fix: negate the quotient if the latched signs differ (signed mode only); negate the remainder if the dividend was negative (signed mode only).
  - Write `result_o`, go to `DivEnd`.
- **`DivEnd`**
  - `ready_o`=`DivResultReady`; `result_o` holds steady.
  - When `start_i` goes to `DivStop`, return to `DivFree` and clear `ready_o` and `result_o` to 0 on that edge.
- **`cancel_i`**
  - High in `DivOn` or `DivByZero`: return to `DivFree` on the next edge. `ready_o` stays low and no result is produced.
  - High in `DivEnd`: return to `DivFree`.
  - Cancel has priority over every other transition.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This is the natural 32-bit wrap; no special case is added.
- **Inputs during an operation:** operand changes after the start cycle are ignored, because all operands are latched in `DivFree`.
- **Async reset mid-operation:** immediate return to the reset values; no partial result is visible.

## Timing
- Start sampled in `DivFree` at edge T:
  - `DivOn` is entered at T+1.
  - 32 iteration edges run from T+1 to T+32, sign fix at T+33.
  - `ready_o` and a valid `result_o` appear after edge T+34. Normal latency is 34 cycles.
- Divide-by-zero: `DivByZero` after T+1, `ready_o` high after T+2.
- `ready_o` stays high for as long as `start_i` is held, with a minimum of 1 cycle. The execute stage must drop `start_i` in the cycle it consumes the result.
- Back-to-back operations:
  - A new start is accepted only in `DivFree`.
  - This gives a minimum of one idle cycle between the `DivEnd` exit and the next `DivOn` entry.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared constants belong in `Defines.v`: `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2-bit encodings), `DivStart`, `DivStop`, `DivResultReady`, `DivResultNotReady`, `DoubleRegBus`, `ZeroWord`.
- `ex_div_ctrl` holds the FSM, counter, operand latches and sign fix.
- Optional combinational sub-module `div_iter_step`: inputs are the 65-bit working register and the 32-bit divisor; outputs are the next working register. Use it when the step logic is reused for a radix-4 upgrade.
- Execute-stage integration:
  - Execute asserts `stallreq_o` while `start_i` is high and `ready_o` is low.
  - Execute selects `result_o[31:0]` (DIV) or `result_o[63:32]` (MOD).

## Test plan
- **Unsigned:** 100 / 7, `signed_div_i`=0 -> `ready_o` high 34 cycles after start, `result_o`={0x00000002, 0x0000000E}.
- **Signed:** -7 / 2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat as unsigned -> quotient 0x7FFFFFFC, remainder 0x00000001.
- **Divide by zero:** 0x12345678 / 0 -> `ready_o` after 2 cycles, `result_o`={0x12345678, 0xFFFFFFFF}.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- **Cancel and reset mid-operation:**
  - Assert `cancel_i` at iteration 10 -> `DivFree` next cycle, `ready_o` never rises, an immediate new start of 9/3 returns {0, 3}.
  - Pull `rst` low at iteration 20 -> all outputs 0 asynchronously.
- **Hold and release:** keep `start_i` high 5 cycles after ready -> `result_o` stable for all 5 cycles. Drop `start_i` -> next edge `ready_o`=0 and `result_o`=0.

Source files
------------

// File: rtl/ex_div_ctrl_pkg.sv
// Shared constants and state encoding for the execute-stage divide sequencer.
package ex_div_ctrl_pkg;

  localparam int unsigned DivW         = 32;
  localparam int unsigned DoubleRegBus = 2 * DivW;
  localparam logic [DivW-1:0] ZeroWord = '0;

  localparam logic RstEnable         = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div_ctrl_if.sv
// Execute-stage <-> divider handshake: operands and start/cancel in, result and ready out.
interface ex_div_ctrl_if
  import ex_div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DivW
);

  logic               signed_div_i;
  logic [DIV_W-1:0]   opdata1_i;
  logic [DIV_W-1:0]   opdata2_i;
  logic               start_i;
  logic               cancel_i;
  logic [2*DIV_W-1:0] result_o;
  logic               ready_o;

  // Execute stage side.
  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output cancel_i,
    input  result_o,
    input  ready_o
  );

  // Divider side.
  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  cancel_i,
    output result_o,
    output ready_o
  );

endinterface

// File: rtl/ex_div_ctrl_div_iter_step.sv
// One restoring-division step: shift the working register, trial-subtract the divisor
// from the upper half and record the quotient bit in bit 0.
module ex_div_ctrl_div_iter_step
  import ex_div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DivW
) (
  input  logic [2*DIV_W:0] i_work,
  input  logic [DIV_W-1:0] i_divisor,
  output logic [2*DIV_W:0] o_work
);

  logic [2*DIV_W:0] w_shift;
  logic [DIV_W+1:0] w_diff;

  always_comb begin
    w_shift = i_work << 1;
    // Extra top bit so a borrow is visible as the sign of the trial difference.
    w_diff  = {1'b0, w_shift[2*DIV_W:DIV_W]} - {2'b00, i_divisor};
    if (!w_diff[DIV_W+1]) begin
      o_work = {w_diff[DIV_W:0], w_shift[DIV_W-1:1], 1'b1};
    end else begin
      o_work = w_shift;
    end
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle signed/unsigned divide sequencer (DIV/MOD .W/.WU), one quotient bit per cycle,
// with divide-by-zero short cut, cancel on flush and a start/ready hold handshake.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DivW
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_ctrl_if.slave div_bus
);

  localparam int unsigned CntW = $clog2(DIV_W + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DIV_W);

  div_state_e         r_state, w_state_nxt;
  logic [CntW-1:0]    r_cnt, w_cnt_nxt;
  logic [2*DIV_W:0]   r_work, w_work_nxt, w_work_step;
  logic [DIV_W-1:0]   r_divisor, w_divisor_nxt;
  logic [DIV_W-1:0]   r_op1_raw, w_op1_raw_nxt;
  logic               r_neg1, w_neg1_nxt;
  logic               r_neg2, w_neg2_nxt;
  logic [2*DIV_W-1:0] r_result, w_result_nxt;
  logic               r_ready, w_ready_nxt;

  logic               w_accept;
  logic               w_div_zero;
  logic               w_iter_done;
  logic               w_neg1_in;
  logic               w_neg2_in;
  logic [DIV_W-1:0]   w_quot;
  logic [DIV_W-1:0]   w_rem;

  assign w_accept    = (div_bus.start_i == DivStart) && !div_bus.cancel_i;
  assign w_div_zero  = (div_bus.opdata2_i == '0);
  assign w_iter_done = (r_cnt == CntDone);
  assign w_neg1_in   = div_bus.signed_div_i & div_bus.opdata1_i[DIV_W-1];
  assign w_neg2_in   = div_bus.signed_div_i & div_bus.opdata2_i[DIV_W-1];

  ex_div_ctrl_div_iter_step #(
    .DIV_W (DIV_W)
  ) u_iter_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_work_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state <= DivFree;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (div_bus.cancel_i) begin
      w_state_nxt = DivFree;
    end else begin
      unique case (r_state)
        DivFree: begin
          if (div_bus.start_i == DivStart) begin
            w_state_nxt = w_div_zero ? DivByZero : DivOn;
          end
        end
        DivByZero: w_state_nxt = DivEnd;
        DivOn: begin
          if (w_iter_done) begin
            w_state_nxt = DivEnd;
          end
        end
        DivEnd: begin
          if (div_bus.start_i == DivStop) begin
            w_state_nxt = DivFree;
          end
        end
        default: w_state_nxt = DivFree;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_work_nxt    = r_work;
    w_divisor_nxt = r_divisor;
    w_op1_raw_nxt = r_op1_raw;
    w_neg1_nxt    = r_neg1;
    w_neg2_nxt    = r_neg2;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    w_quot        = r_work[DIV_W-1:0];
    w_rem         = r_work[2*DIV_W-1:DIV_W];

    unique case (r_state)
      DivFree: begin
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = '0;
        if (w_accept) begin
          // Raw dividend kept for the divide-by-zero remainder.
          w_op1_raw_nxt = div_bus.opdata1_i;
          w_neg1_nxt    = w_neg1_in;
          w_neg2_nxt    = w_neg2_in;
          w_divisor_nxt = w_neg2_in ? -div_bus.opdata2_i : div_bus.opdata2_i;
          w_cnt_nxt     = '0;
          w_work_nxt    = {{(DIV_W + 1){1'b0}},
                           (w_neg1_in ? -div_bus.opdata1_i : div_bus.opdata1_i)};
        end
      end
      DivByZero: begin
        w_result_nxt = {r_op1_raw, {DIV_W{1'b1}}};
      end
      DivOn: begin
        if (!w_iter_done) begin
          w_work_nxt = w_work_step;
          w_cnt_nxt  = r_cnt + CntW'(1);
        end else begin
          if (r_neg1 ^ r_neg2) begin
            w_quot = -r_work[DIV_W-1:0];
          end
          if (r_neg1) begin
            w_rem = -r_work[2*DIV_W-1:DIV_W];
          end
          w_result_nxt = {w_rem, w_quot};
        end
      end
      DivEnd: begin
        if (div_bus.start_i == DivStop) begin
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = '0;
        end else begin
          w_ready_nxt  = DivResultReady;
        end
      end
      default: begin
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = '0;
      end
    endcase

    if (div_bus.cancel_i) begin
      w_ready_nxt  = DivResultNotReady;
      w_result_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_op1_raw <= '0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_work    <= w_work_nxt;
      r_divisor <= w_divisor_nxt;
      r_op1_raw <= w_op1_raw_nxt;
      r_neg1    <= w_neg1_nxt;
      r_neg2    <= w_neg2_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign div_bus.result_o = r_result;
  assign div_bus.ready_o  = r_ready;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed bench for ex_div_ctrl: latency, signed/unsigned results, divide-by-zero,
// overflow, cancel, asynchronous reset and the start/ready hold handshake.
module tb_ex_div_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ex_div_ctrl_if #(.DIV_W(32)) div_bus ();

  ex_div_ctrl #(
    .DIV_W (32)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .div_bus (div_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Called in the low clock phase; returns after the first sample with ready high.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    div_bus.signed_div_i = sgn;
    div_bus.opdata1_i    = a;
    div_bus.opdata2_i    = b;
    div_bus.start_i      = 1'b1;
    div_bus.cancel_i     = 1'b0;
    @(posedge clk);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (div_bus.ready_o) begin
        lat = n;
        break;
      end
    end
    res = div_bus.result_o;
  endtask

  task automatic release_op();
    @(negedge clk);
    div_bus.start_i  = 1'b0;
    div_bus.cancel_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst                  = 1'b0;
    div_bus.signed_div_i = 1'b0;
    div_bus.opdata1_i    = '0;
    div_bus.opdata2_i    = '0;
    div_bus.start_i      = 1'b0;
    div_bus.cancel_i     = 1'b0;
    #1;
    n_checks++;
    if (div_bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0", div_bus.ready_o);
    end
    n_checks++;
    if (div_bus.result_o !== 64'h0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 0", div_bus.result_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({div_bus.ready_o, div_bus.result_o} !== 65'h0) begin
      n_fail++; $display("FAIL idle_outputs: got %b/%h expected 0/0",
                         div_bus.ready_o, div_bus.result_o);
    end
  endtask

  task automatic test_unsigned();
    logic [63:0] res;
    int          lat;
    @(negedge clk);
    // Operands scrambled after the start edge must be ignored.
    fork
      run_op(1'b0, 32'd100, 32'd7, res, lat);
      begin
        @(posedge clk);
        #2;
        div_bus.opdata1_i = 32'hDEAD_BEEF;
        div_bus.opdata2_i = 32'h0;
      end
    join
    n_checks++;
    if (lat !== 34) begin
      n_fail++; $display("FAIL unsigned_latency: got %0d expected 34", lat);
    end
    n_checks++;
    if (res !== 64'h00000002_0000000E) begin
      n_fail++; $display("FAIL unsigned_100_7: got %h expected 000000020000000e", res);
    end
    release_op();
    @(negedge clk);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, res, lat);
    n_checks++;
    if (res !== 64'h00000000_FFFFFFFF) begin
      n_fail++; $display("FAIL unsigned_max_by_1: got %h expected 00000000ffffffff", res);
    end
    release_op();
    @(negedge clk);
    run_op(1'b0, 32'd5, 32'd9, res, lat);
    n_checks++;
    if (res !== 64'h00000005_00000000) begin
      n_fail++; $display("FAIL unsigned_small: got %h expected 0000000500000000", res);
    end
    release_op();
  endtask

  task automatic test_signed();
    logic [63:0] res;
    int          lat;
    @(negedge clk);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat);
    n_checks++;
    if (lat !== 34) begin
      n_fail++; $display("FAIL signed_latency: got %0d expected 34", lat);
    end
    n_checks++;
    if (res !== 64'hFFFFFFFF_FFFFFFFD) begin
      n_fail++; $display("FAIL signed_m7_2: got %h expected fffffffffffffffd", res);
    end
    release_op();
    @(negedge clk);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, res, lat);
    n_checks++;
    if (res !== 64'h00000001_7FFFFFFC) begin
      n_fail++; $display("FAIL unsigned_fff9_2: got %h expected 000000017ffffffc", res);
    end
    release_op();
    @(negedge clk);
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, res, lat);
    n_checks++;
    if (res !== 64'hFFFFFFFE_FFFFFFF2) begin
      n_fail++; $display("FAIL signed_m100_7: got %h expected fffffffefffffff2", res);
    end
    release_op();
    @(negedge clk);
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, res, lat);
    n_checks++;
    if (res !== 64'h00000002_FFFFFFF2) begin
      n_fail++; $display("FAIL signed_100_m7: got %h expected 00000002fffffff2", res);
    end
    release_op();
  endtask

  task automatic test_div_zero();
    logic [63:0] res;
    int          lat;
    @(negedge clk);
    run_op(1'b0, 32'h1234_5678, 32'h0, res, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++; $display("FAIL divzero_latency: got %0d expected 2", lat);
    end
    n_checks++;
    if (res !== 64'h12345678_FFFFFFFF) begin
      n_fail++; $display("FAIL divzero_result: got %h expected 12345678ffffffff", res);
    end
    release_op();
    @(negedge clk);
    run_op(1'b1, 32'h8000_0000, 32'h0, res, lat);
    n_checks++;
    if (res !== 64'h80000000_FFFFFFFF) begin
      n_fail++; $display("FAIL divzero_signed: got %h expected 80000000ffffffff", res);
    end
    release_op();
  endtask

  task automatic test_overflow();
    logic [63:0] res;
    int          lat;
    @(negedge clk);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_checks++;
    if (res !== 64'h00000000_80000000) begin
      n_fail++; $display("FAIL signed_overflow: got %h expected 0000000080000000", res);
    end
    release_op();
    @(negedge clk);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_checks++;
    if (res !== 64'h80000000_00000000) begin
      n_fail++; $display("FAIL unsigned_8000_ffff: got %h expected 8000000000000000", res);
    end
    release_op();
  endtask

  task automatic test_cancel();
    logic [63:0] res;
    int          lat;
    logic        seen_ready;
    seen_ready = 1'b0;
    @(negedge clk);
    div_bus.signed_div_i = 1'b0;
    div_bus.opdata1_i    = 32'd100;
    div_bus.opdata2_i    = 32'd7;
    div_bus.start_i      = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      seen_ready |= div_bus.ready_o;
    end
    @(negedge clk);
    div_bus.cancel_i = 1'b1;
    @(posedge clk);
    #1;
    seen_ready |= div_bus.ready_o;
    n_checks++;
    if (seen_ready !== 1'b0) begin
      n_fail++; $display("FAIL cancel_no_ready: got %b expected 0", seen_ready);
    end
    n_checks++;
    if (div_bus.result_o !== 64'h0) begin
      n_fail++; $display("FAIL cancel_result: got %h expected 0", div_bus.result_o);
    end
    @(negedge clk);
    run_op(1'b0, 32'd9, 32'd3, res, lat);
    n_checks++;
    if (lat !== 34) begin
      n_fail++; $display("FAIL restart_latency: got %0d expected 34", lat);
    end
    n_checks++;
    if (res !== 64'h00000000_00000003) begin
      n_fail++; $display("FAIL restart_9_3: got %h expected 0000000000000003", res);
    end
    release_op();
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int          lat;
    logic        seen_ready;
    seen_ready = 1'b0;
    @(negedge clk);
    div_bus.signed_div_i = 1'b0;
    div_bus.opdata1_i    = 32'd100;
    div_bus.opdata2_i    = 32'd7;
    div_bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({div_bus.ready_o, div_bus.result_o} !== 65'h0) begin
      n_fail++; $display("FAIL rst_mid_op: got %b/%h expected 0/0",
                         div_bus.ready_o, div_bus.result_o);
    end
    @(negedge clk);
    div_bus.start_i = 1'b0;
    rst             = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen_ready |= div_bus.ready_o;
    end
    n_checks++;
    if (seen_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_stale_op: got ready %b expected 0", seen_ready);
    end
    // Reset while a result is on display must clear it before any clock edge.
    @(negedge clk);
    run_op(1'b0, 32'd5, 32'd9, res, lat);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({div_bus.ready_o, div_bus.result_o} !== 65'h0) begin
      n_fail++; $display("FAIL rst_async_end: got %b/%h expected 0/0",
                         div_bus.ready_o, div_bus.result_o);
    end
    @(negedge clk);
    div_bus.start_i = 1'b0;
    rst             = 1'b1;
  endtask

  task automatic test_hold_release();
    logic [63:0] res;
    int          lat;
    int          bad;
    bad = 0;
    @(negedge clk);
    run_op(1'b0, 32'd1000, 32'd10, res, lat);
    n_checks++;
    if (res !== 64'h00000000_00000064) begin
      n_fail++; $display("FAIL hold_result: got %h expected 0000000000000064", res);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (div_bus.ready_o !== 1'b1 || div_bus.result_o !== 64'h00000000_00000064) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
    end
    release_op();
    n_checks++;
    if ({div_bus.ready_o, div_bus.result_o} !== 65'h0) begin
      n_fail++; $display("FAIL release_clear: got %b/%h expected 0/0",
                         div_bus.ready_o, div_bus.result_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int          lat;
    @(negedge clk);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, res, lat);
    n_checks++;
    if (lat !== 34) begin
      n_fail++; $display("FAIL b2b_latency_1: got %0d expected 34", lat);
    end
    n_checks++;
    if (res !== 64'h0000000F_0FFFFFFF) begin
      n_fail++; $display("FAIL b2b_result_1: got %h expected 0000000f0fffffff", res);
    end
    release_op();
    @(negedge clk);
    run_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, res, lat);
    n_checks++;
    if (lat !== 34) begin
      n_fail++; $display("FAIL b2b_latency_2: got %0d expected 34", lat);
    end
    n_checks++;
    if (res !== 64'hFFFFFFFE_0000000E) begin
      n_fail++; $display("FAIL b2b_result_2: got %h expected fffffffe0000000e", res);
    end
    release_op();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_cancel();
    test_async_reset();
    test_hold_release();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
